d_fifo_drain_arbiter: RTL and testbench

//  Downstream consumer of the full-logic D0/D1 destination FIFOs. Pops both FIFOs

---
 rtl/d_fifo_drain_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_d_fifo_drain_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_fifo_drain_arbiter.sv
// Round-robin drain of the D0/D1 destination FIFOs into one valid/ready stream tagged with source.
// Latency: pop in cycle N -> word on data_out in cycle N+2 when the output buffer is empty.
// Backpressure: pops are credit-limited so at most 2 words sit in buffer+flight; out_ready low holds the head.
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   active_in, error_in   : full-logic ACTIVE state / error abort
//   empty_D*, data_D*     : FIFO status and read data (data valid the cycle after a pop)
//   D0_pop, D1_pop        : combinational FIFO pops
//   data_out, valid_out,
//   src_out, out_ready    : output stream (src_out 0 = D0, 1 = D1)
//   cnt_D0, cnt_D1        : per-source delivered-word counters (wrap)
//   busy                  : FSM not in IDLE
module d_fifo_drain_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active_in,
  input  logic                  error_in,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  input  logic [DATA_WIDTH-1:0] data_D0,
  input  logic [DATA_WIDTH-1:0] data_D1,
  input  logic                  out_ready,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state, state_next;

  // Two-entry output buffer; head drives the outputs directly.
  logic [DATA_WIDTH-1:0] head_dat, tail_dat;
  logic                  head_src, tail_src;
  logic [1:0]            occ;

  // A pop issued last cycle whose data is on data_D{pend_src} now.
  logic                  pending;
  logic                  pend_src;

  // Source preferred when both FIFOs have data (opposite of the last grant).
  logic                  rr;

  logic                  deq;
  logic                  credit_ok;
  logic                  grant_vld;
  logic                  grant_src;
  logic                  discard;
  logic [DATA_WIDTH-1:0] cap_dat;
  logic [1:0]            wr_idx;

  assign valid_out = (occ != 2'd0);
  assign deq       = valid_out & out_ready;
  assign data_out  = head_dat;
  assign src_out   = head_src;
  assign busy      = (state != IDLE);

  // occ + pending - deq < 2, rearranged to stay unsigned.
  assign credit_ok = ({1'b0, occ} + {2'b00, pending}) < (3'd2 + {2'b00, deq});

  assign cap_dat = pend_src ? data_D1 : data_D0;
  // Tail slot as seen after this cycle's dequeue shifts the buffer.
  assign wr_idx  = occ - {1'b0, deq};

  // Buffer and in-flight word are dropped on the edge that enters ERR.
  assign discard = (state_next == ERR);

  always_comb begin
    grant_vld = 1'b0;
    grant_src = 1'b0;
    if ((state == RUN) && credit_ok && !reset) begin
      if (!empty_D0 && !empty_D1) begin
        grant_vld = 1'b1;
        grant_src = rr;
      end else if (!empty_D0) begin
        grant_vld = 1'b1;
        grant_src = 1'b0;
      end else if (!empty_D1) begin
        grant_vld = 1'b1;
        grant_src = 1'b1;
      end
    end
  end

  assign D0_pop = grant_vld & ~grant_src;
  assign D1_pop = grant_vld &  grant_src;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (active_in && !error_in) state_next = RUN;
      end
      RUN: begin
        if (error_in)        state_next = ERR;
        else if (!active_in) state_next = FLUSH;
      end
      FLUSH: begin
        if (error_in)                          state_next = ERR;
        else if ((occ == 2'd0) && !pending)    state_next = IDLE;
      end
      ERR: begin
        if (!error_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      pending  <= 1'b0;
      pend_src <= 1'b0;
      rr       <= 1'b0;
      head_dat <= '0;
      head_src <= 1'b0;
      tail_dat <= '0;
      tail_src <= 1'b0;
    end else begin
      if (grant_vld) begin
        rr       <= ~grant_src;
        pend_src <= grant_src;
      end
      if (discard) begin
        occ     <= 2'd0;
        pending <= 1'b0;
      end else begin
        pending <= grant_vld;
        occ     <= occ + {1'b0, pending} - {1'b0, deq};
        if (deq) begin
          head_dat <= tail_dat;
          head_src <= tail_src;
        end
        // Capture after the shift so a same-cycle deq+capture keeps order.
        if (pending) begin
          if (wr_idx == 2'd0) begin
            head_dat <= cap_dat;
            head_src <= pend_src;
          end else begin
            tail_dat <= cap_dat;
            tail_src <= pend_src;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_D0 <= '0;
      cnt_D1 <= '0;
    end else if (deq) begin
      if (head_src) cnt_D1 <= cnt_D1 + 1'b1;
      else          cnt_D0 <= cnt_D0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_d_fifo_drain_arbiter.sv
module tb_d_fifo_drain_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active_in = 1'b0;
  logic       error_in = 1'b0;
  logic       empty_D0, empty_D1;
  logic [5:0] data_D0 = '0;
  logic [5:0] data_D1 = '0;
  logic       out_ready = 1'b0;
  logic       D0_pop, D1_pop;
  logic [5:0] data_out;
  logic       valid_out, src_out;
  logic [4:0] cnt_D0, cnt_D1;
  logic       busy;

  int checks = 0;
  int errors = 0;

  d_fifo_drain_arbiter #(.DATA_WIDTH(6), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .active_in(active_in), .error_in(error_in),
    .empty_D0(empty_D0), .empty_D1(empty_D1), .data_D0(data_D0), .data_D1(data_D1),
    .out_ready(out_ready), .D0_pop(D0_pop), .D1_pop(D1_pop), .data_out(data_out),
    .valid_out(valid_out), .src_out(src_out), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO models with registered read data, plus a log of delivered words.
  logic       push0 = 1'b0, push1 = 1'b0;
  logic [5:0] push_dat0 = '0, push_dat1 = '0;
  logic [5:0] m0 [64];
  logic [5:0] m1 [64];
  logic [6:0] wr0 = '0, rd0 = '0, wr1 = '0, rd1 = '0;
  int         pops0 = 0, pops1 = 0;
  logic [5:0] log_dat [128];
  logic       log_src [128];
  int         log_n = 0;

  assign empty_D0 = (wr0 == rd0);
  assign empty_D1 = (wr1 == rd1);

  always @(posedge clk) begin
    if (push0) begin m0[wr0[5:0]] <= push_dat0; wr0 <= wr0 + 7'd1; end
    if (push1) begin m1[wr1[5:0]] <= push_dat1; wr1 <= wr1 + 7'd1; end
    if (D0_pop) begin data_D0 <= m0[rd0[5:0]]; rd0 <= rd0 + 7'd1; pops0 <= pops0 + 1; end
    if (D1_pop) begin data_D1 <= m1[rd1[5:0]]; rd1 <= rd1 + 7'd1; pops1 <= pops1 + 1; end
    if (!reset && valid_out && out_ready) begin
      log_dat[log_n[6:0]] <= data_out;
      log_src[log_n[6:0]] <= src_out;
      log_n <= log_n + 1;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_both(input logic en0, input logic [5:0] d0,
                           input logic en1, input logic [5:0] d1);
    push0 = en0; push_dat0 = d0;
    push1 = en1; push_dat1 = d1;
    tick();
    push0 = 1'b0; push1 = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; active_in = 1'b0; error_in = 1'b0; out_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    push_both(1'b1, 6'b110100, 1'b0, 6'd0);
    push_both(1'b1, 6'b110101, 1'b0, 6'd0);
    checks++;
    if (D0_pop !== 1'b0 || D1_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b%b want 00", D0_pop, D1_pop); end
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0 || data_out !== 6'd0 || src_out !== 1'b0) begin
      errors++; $display("FAIL reset_out got v=%b b=%b d=%b s=%b want 0 0 000000 0", valid_out, busy, data_out, src_out);
    end
    checks++;
    if (cnt_D0 !== 5'd0 || cnt_D1 !== 5'd0) begin errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", cnt_D0, cnt_D1); end
    reset = 1'b0;
    tick(3);
    checks++;
    if (pops0 !== 0 || D0_pop !== 1'b0) begin errors++; $display("FAIL inactive_pops got %0d want 0", pops0); end
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL inactive_idle got v=%b b=%b want 0 0", valid_out, busy); end
  endtask

  task automatic test_single_source();
    active_in = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (D0_pop !== 1'b1 || D1_pop !== 1'b0) begin errors++; $display("FAIL ss_pop1 got %b%b want 10", D0_pop, D1_pop); end
    tick();
    checks++;
    if (D0_pop !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL ss_pop2 got pop=%b v=%b want 1 0", D0_pop, valid_out); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'b110100 || src_out !== 1'b0) begin
      errors++; $display("FAIL ss_word0 got v=%b d=%b s=%b want 1 110100 0", valid_out, data_out, src_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'b110101 || cnt_D0 !== 5'd1) begin
      errors++; $display("FAIL ss_word1 got v=%b d=%b c=%0d want 1 110101 1", valid_out, data_out, cnt_D0);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || cnt_D0 !== 5'd2 || D0_pop !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ss_done got v=%b c=%0d pop=%b b=%b want 0 2 0 1", valid_out, cnt_D0, D0_pop, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_d [6];
    exp_d = '{6'o01, 6'o41, 6'o02, 6'o42, 6'o03, 6'o43};
    reset_dut();
    for (int i = 0; i < 3; i++) push_both(1'b1, exp_d[2*i], 1'b1, exp_d[2*i+1]);
    active_in = 1'b1; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (D0_pop !== (k < 6 && k % 2 == 0) || D1_pop !== (k < 6 && k % 2 == 1)) begin
        errors++; $display("FAIL rr_pop k=%0d got %b%b", k, D0_pop, D1_pop);
      end
      if (k >= 2) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp_d[k-2] || src_out !== 1'((k-2) % 2)) begin
          errors++; $display("FAIL rr_out k=%0d got v=%b d=%o s=%b want 1 %o %0d", k, valid_out, data_out, src_out, exp_d[k-2], (k-2) % 2);
        end
      end
      tick();
    end
    checks++;
    if (cnt_D0 !== 5'd3 || cnt_D1 !== 5'd3 || valid_out !== 1'b0) begin
      errors++; $display("FAIL rr_cnt got %0d %0d v=%b want 3 3 0", cnt_D0, cnt_D1, valid_out);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_d [8];
    int pbase, lbase;
    exp_d = '{6'o11, 6'o51, 6'o12, 6'o52, 6'o13, 6'o53, 6'o14, 6'o54};
    reset_dut();
    for (int i = 0; i < 4; i++) push_both(1'b1, exp_d[2*i], 1'b1, exp_d[2*i+1]);
    pbase = pops0 + pops1; lbase = log_n;
    active_in = 1'b1; out_ready = 1'b0;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (D0_pop !== 1'b0 || D1_pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 6'o11 || src_out !== 1'b0) begin
        errors++; $display("FAIL bp_hold k=%0d got pop=%b%b v=%b d=%o s=%b want 00 1 11 0", k, D0_pop, D1_pop, valid_out, data_out, src_out);
      end
      tick();
    end
    checks++;
    if (pops0 + pops1 - pbase !== 2) begin errors++; $display("FAIL bp_pops got %0d want 2", pops0 + pops1 - pbase); end
    out_ready = 1'b1;
    tick(14);
    checks++;
    if (log_n - lbase !== 8 || cnt_D0 !== 5'd4 || cnt_D1 !== 5'd4) begin
      errors++; $display("FAIL bp_count got n=%0d c=%0d %0d want 8 4 4", log_n - lbase, cnt_D0, cnt_D1);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_dat[lbase+i] !== exp_d[i] || log_src[lbase+i] !== 1'(i % 2)) begin
        errors++; $display("FAIL bp_order i=%0d got %o/%b want %o/%0d", i, log_dat[lbase+i], log_src[lbase+i], exp_d[i], i % 2);
      end
    end
  endtask

  task automatic test_flush();
    int pbase, lbase;
    reset_dut();
    for (int i = 0; i < 6; i++) push_both(1'b1, 6'(8 + i), 1'b0, 6'd0);
    pbase = pops0; lbase = log_n;
    active_in = 1'b1; out_ready = 1'b1;
    tick(3);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd8) begin errors++; $display("FAIL fl_first got v=%b d=%0d want 1 8", valid_out, data_out); end
    tick();
    checks++;
    if (D0_pop !== 1'b1) begin errors++; $display("FAIL fl_lastpop got %b want 1", D0_pop); end
    active_in = 1'b0;
    tick();
    checks++;
    if (D0_pop !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fl_nopop got pop=%b b=%b want 0 1", D0_pop, busy); end
    tick();
    checks++;
    if (D0_pop !== 1'b0 || valid_out !== 1'b1 || data_out !== 6'd11) begin
      errors++; $display("FAIL fl_drain got pop=%b v=%b d=%0d want 0 1 11", D0_pop, valid_out, data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fl_empty got v=%b b=%b want 0 1", valid_out, busy); end
    tick();
    checks++;
    if (busy !== 1'b0 || pops0 - pbase !== 4 || log_n - lbase !== 4 || cnt_D0 !== 5'd4) begin
      errors++; $display("FAIL fl_idle got b=%b pops=%0d n=%0d c=%0d want 0 4 4 4", busy, pops0 - pbase, log_n - lbase, cnt_D0);
    end
  endtask

  task automatic test_error_and_wrap();
    int lbase;
    reset_dut();
    // D0 still holds the two words left over from the flush test.
    active_in = 1'b1; out_ready = 1'b0;
    tick(2);
    checks++;
    if (D0_pop !== 1'b1) begin errors++; $display("FAIL er_pop got %b want 1", D0_pop); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 6'd12) begin errors++; $display("FAIL er_occ1 got v=%b d=%0d want 1 12", valid_out, data_out); end
    error_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || D0_pop !== 1'b0 || D1_pop !== 1'b0 || busy !== 1'b1 || cnt_D0 !== 5'd0) begin
      errors++; $display("FAIL er_abort got v=%b pop=%b%b b=%b c=%0d want 0 00 1 0", valid_out, D0_pop, D1_pop, busy, cnt_D0);
    end
    error_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL er_idle got b=%b v=%b want 0 0", busy, valid_out); end
    tick();
    out_ready = 1'b1;
    lbase = log_n;
    for (int i = 1; i <= 31; i++) push_both(1'b1, 6'(i), 1'b0, 6'd0);
    tick(8);
    checks++;
    if (cnt_D0 !== 5'd31 || log_n - lbase !== 31) begin errors++; $display("FAIL wrap_31 got c=%0d n=%0d want 31 31", cnt_D0, log_n - lbase); end
    push_both(1'b1, 6'd32, 1'b0, 6'd0);
    tick(6);
    checks++;
    if (cnt_D0 !== 5'd0 || cnt_D1 !== 5'd0) begin errors++; $display("FAIL wrap_0 got %0d %0d want 0 0", cnt_D0, cnt_D1); end
    checks++;
    if (log_dat[lbase+31] !== 6'd32 || log_src[lbase+31] !== 1'b0) begin
      errors++; $display("FAIL wrap_last got %0d/%b want 32/0", log_dat[lbase+31], log_src[lbase+31]);
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_error_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
